// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. A four-state fetch FSM issues at most
//               one outstanding request to instruction memory. Each response is
//               paired with the PC of the request that produced it and pushed
//               into a small FIFO. The FIFO head is presented to decode.
//               A redirect flushes the FIFO and restarts fetch at the new PC.
//               Any response that belongs to the abandoned path is dropped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PC_RESET        : PC of the first fetch after reset
//   QDEPTH          : instruction-queue entries (2 or 4)
// Ports
//   clk             : in   1  clock, rising edge
//   rst_n           : in   1  asynchronous active-low reset
//   imem_req_valid  : out  1  fetch request valid
//   imem_req_ready  : in   1  memory accepts request
//   imem_req_addr   : out 64  fetch address (word aligned)
//   imem_resp_valid : in   1  response valid (never back-pressured)
//   imem_resp_data  : in  32  fetched instruction word
//   redirect_valid  : in   1  flush and refetch from redirect_pc
//   redirect_pc     : in  64  new fetch PC
//   if_valid        : out  1  inst/inst_addr hold a real instruction
//   if_ready        : in   1  decode consumes the head entry
//   inst            : out 32  head instruction (NOP when empty)
//   inst_addr       : out 64  PC of head instruction (0 when empty)
// ============================================================================
module if_stage #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_addr
);

  // Only depths 2 and 4 are supported, so pointers are 1 or 2 bits wide.
  localparam int              PW       = (QDEPTH > 2) ? 2 : 1;
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   C_QDEPTH = CW'(QDEPTH);
  localparam logic [31:0]     C_NOP    = 32'h0000_0013;
  localparam logic [63:0]     C_PC_RST = {PC_RESET[63:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t         r_state;
  logic [63:0]    r_pc;
  logic [63:0]    r_req_pc;     // PC of the request currently outstanding
  logic [31:0]    r_q_inst [QDEPTH];
  logic [63:0]    r_q_pc   [QDEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  logic           w_req_valid;
  logic           w_req_fire;
  logic           w_resp_in_wait;
  logic           w_push;
  logic           w_pop;
  logic           w_if_valid;
  logic [63:0]    w_redirect_pc;
  logic           w_unused_redirect_lsbs;

  // Low bits of the redirect target are forced to zero; keep them visibly sunk.
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];
  assign w_redirect_pc          = {redirect_pc[63:2], 2'b00};

  // Request qualification depends only on registers, so the address stays
  // stable across a stalled handshake. Occupancy cannot rise while in FETCH,
  // so a raised valid is never withdrawn except by a redirect.
  assign w_req_valid    = (r_state == S_FETCH) && (r_count < C_QDEPTH);
  assign w_req_fire     = w_req_valid & imem_req_ready;
  assign w_resp_in_wait = (r_state == S_WAIT) & imem_resp_valid;

  // A redirect discards the coincident response and overrides any pop.
  assign w_if_valid = (r_count != '0);
  assign w_push     = w_resp_in_wait & ~redirect_valid;
  assign w_pop      = w_if_valid & if_ready & ~redirect_valid;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = w_if_valid;
  assign inst           = w_if_valid ? r_q_inst[r_rd_ptr] : C_NOP;
  assign inst_addr      = w_if_valid ? r_q_pc[r_rd_ptr]   : 64'h0;

  // --------------------------------------------------------------------------
  // Fetch FSM and PC
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= C_PC_RST;
      r_req_pc <= C_PC_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            // A request accepted on the redirect edge is now stale; its
            // response must be swallowed.
            r_state <= w_req_fire ? S_DROP : S_FETCH;
          end else if (w_req_fire) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 64'd4;
            r_state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= imem_resp_valid ? S_FETCH : S_DROP;
          end else if (imem_resp_valid) begin
            r_state <= S_FETCH;
          end
        end

        S_DROP: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end else if (imem_resp_valid) begin
            r_state <= S_FETCH;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Instruction queue
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_inst[i] <= C_NOP;
        r_q_pc[i]   <= 64'h0;
      end
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_inst[r_wr_ptr] <= imem_resp_data;
        r_q_pc[r_wr_ptr]   <= r_req_pc;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: PC_RESET, 64'h0000_0000_8000_0000, PC of the first fetch after reset.
REQ-002 Parameter: QDEPTH, 2, instruction-queue entries; legal values 2 and 4 only.
REQ-003 Port: clk  in  1  sole clock, all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  one clock; reset asynchronous, active-low.
REQ-005 Port: imem_req_valid  out  1  fetch request valid.
REQ-006 Port: imem_req_ready  in  1  memory accepts request.
REQ-007 Port: imem_req_addr  out  64  fetch address, bits [1:0] always 0.
REQ-008 Port: imem_resp_valid  in  1  response data valid; always accepted, no backpressure.
REQ-009 Port: imem_resp_data  in  32  fetched instruction word.
REQ-010 Port: redirect_valid  in  1  branch/jump taken, flush and refetch.
REQ-011 Port: redirect_pc  in  64  new fetch PC.
REQ-012 Port: if_valid  out  1  inst/inst_addr hold a real instruction.
REQ-013 Port: if_ready  in  1  decode consumes the head entry this cycle.
REQ-014 Port: inst  out  32  head instruction to decode.
REQ-015 Port: inst_addr  out  64  PC of head instruction.

Function
REQ-016 Fetch FSM SHALL have states IDLE, FETCH, WAIT, DROP; at most one request outstanding.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-018 FETCH SHALL assert imem_req_valid only while (queue occupancy) < QDEPTH; imem_req_addr = pc.
REQ-019 Request handshake (valid & ready) SHALL set pc <= pc + 4 (64-bit wrap) and move FETCH -> WAIT.
REQ-020 imem_req_addr SHALL stay stable while valid & ~ready, except on redirect, which may change or withdraw it.
REQ-021 In WAIT, imem_resp_valid SHALL push {resp_data, request PC} into the queue and return to FETCH the same edge.
REQ-022 Response latency from memory is unbounded; minimum 1 cycle after request handshake.
REQ-023 Queue SHALL be FIFO; if_valid = queue non-empty; inst/inst_addr = head entry, combinational from registers.
REQ-024 When if_valid = 0, inst SHALL read 32'h0000_0013 (NOP) and inst_addr 64'h0.
REQ-025 Head SHALL be popped on if_valid & if_ready; push and pop in the same cycle SHALL both occur, occupancy unchanged.
REQ-026 Push into a full queue SHALL not occur (guaranteed by REQ-018); occupancy never exceeds QDEPTH.
REQ-027 redirect_valid SHALL: flush the queue (if_valid = 0 next cycle), set pc <= {redirect_pc[63:2], 2'b00}; pop in that cycle ignored.
REQ-028 Redirect in FETCH without handshake -> FETCH; with handshake same cycle -> DROP.
REQ-029 Redirect in WAIT without response -> DROP; with response same cycle -> response discarded, -> FETCH.
REQ-030 Redirect in DROP -> pc updated, stay DROP; redirect in IDLE -> pc updated, -> FETCH.
REQ-031 DROP SHALL deassert imem_req_valid and discard the next imem_resp_valid, then go to FETCH.
REQ-032 imem_resp_valid outside WAIT/DROP is a protocol error; SHALL be ignored.
REQ-033 Throughput with zero-wait memory and if_ready = 1: one instruction every 2 cycles (one outstanding limit).

Reset
REQ-034 rst_n low SHALL asynchronously force: state IDLE, pc = PC_RESET, queue empty, imem_req_valid = 0, if_valid = 0, inst = 32'h13, inst_addr = 0.
REQ-035 Reset mid-transaction SHALL abandon the outstanding request; responses arriving in IDLE are ignored.
REQ-036 Reset release SHALL be synchronous to clk at the flop level (deassertion sampled at a rising edge).

Verification
REQ-037 Reset release, ready = 1, 1-cycle memory: first req addr 0x8000_0000, then 0x8000_0004; if_valid first high with inst_addr 0x8000_0000.
REQ-038 if_ready = 0 for 10 cycles: exactly QDEPTH entries fetched, imem_req_valid low afterward; releasing if_ready drains in order 0x8000_0000, +4, ...
REQ-039 Redirect to 0x8000_0102 while WAIT: next response discarded, next request addr 0x8000_0100, no stale inst reaches if_valid.
REQ-040 Redirect coincident with response and with pop: queue empty next cycle, state FETCH, next req addr = redirect target.
REQ-041 pc = 64'hFFFF_FFFF_FFFF_FFFC fetched: next request addr 64'h0.
REQ-042 rst_n asserted while WAIT with full queue: all outputs at reset values immediately, late response ignored, fetch restarts at PC_RESET.
